// File: rtl/mux_scan_pkg.sv
// Shared constants, state encoding and helpers for the 4-channel scan controller.
// Pure declarations: no latency, no flow control.
package mux_scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_scan_ctrl_rr_pick4.sv
// Round-robin picker: first set req bit searching upward from ptr+1, wrapping.
// Combinational, zero latency; no flow control.
module rr_pick4
  import mux_scan_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [NCH-1:0]   req,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1) so
  // the nearest set bit is the last write and therefore wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = NCH; i >= 1; i--) begin
      cand = ptr + i[SEL_W-1:0];
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Round-robin scan over four channels driving a 4:1 mux select, registered sample out.
// Latency: req seen in IDLE -> grant two edges later -> out_valid one edge after grant.
// No backpressure: a grant lasts DWELL cycles or until its req drops or en falls.
module mux4_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   grant,
  output logic             out,
  output logic             out_valid
);

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [NCH-1:0]   grant_n;
  logic             out_n;
  logic             out_valid_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [NCH-1:0]   din;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             release_now;

  assign din = {in3, in2, in1, in0};

  rr_pick4 u_pick (
    .ptr   (ptr),
    .req   (req),
    .idx   (pick),
    .found (found)
  );

  assign release_now = !en || (cnt == '0) || !req[sel];

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    grant_n     = grant;
    out_n       = out;
    out_valid_n = 1'b0;
    cnt_n       = cnt;
    ptr_n       = ptr;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (en && |req) state_n = ARB;
      end
      ARB: begin
        if (en && found) begin
          sel_n   = pick;
          grant_n = onehot(pick);
          cnt_n   = DWELL_M1;
          state_n = HOLD;
        end else begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      HOLD: begin
        // Every granted cycle yields one sample, including the releasing one.
        out_n       = din[sel];
        out_valid_n = 1'b1;
        cnt_n       = cnt - CNT_W'(1);
        if (release_now) begin
          grant_n = '0;
          cnt_n   = '0;
          ptr_n   = sel;
          state_n = (en && |req) ? ARB : IDLE;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // sel is only rewritten on a new grant, so the mux never glitches between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      grant     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
      ptr       <= SEL_W'(NCH - 1);
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench: two DUTs (DWELL=4 and DWELL=1) share stimulus, checked against a
// queue-fed reference of the round-robin dwell rules.
module tb_mux4_scan_ctrl;

  localparam int P_IDLE = 0;
  localparam int P_ARB  = 1;
  localparam int P_HOLD = 2;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       out;
    logic       ov;
  } exp_t;
  typedef exp_t [1:0] exp2_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [3:0]      req;
  logic [3:0]      din;
  logic [1:0][1:0] sel;
  logic [1:0][3:0] grant;
  logic [1:0]      out;
  logic [1:0]      ov;

  int nvec = 0;
  int nerr = 0;

  int dw     [2] = '{4, 1};
  int m_ph   [2];
  int m_own  [2];
  int m_left [2];
  int m_last [2];
  bit m_g    [2];
  bit m_v    [2];
  bit m_out  [2];

  exp2_t qc[$];
  bit    qs0[$];
  bit    qs1[$];

  always #5 clk = ~clk;

  mux4_scan_ctrl #(.DWELL(4), .CNT_W(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .sel(sel[0]), .grant(grant[0]), .out(out[0]), .out_valid(ov[0])
  );

  mux4_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .sel(sel[1]), .grant(grant[1]), .out(out[1]), .out_valid(ov[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference: phases, owner, grant cycles left, last-served channel.
  initial begin
    exp2_t e;
    int    c;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_ph[k] = P_IDLE; m_own[k] = 0; m_left[k] = 0; m_last[k] = 3;
          m_g[k] = 0; m_v[k] = 0; m_out[k] = 0;
        end else begin
          m_v[k] = 0;
          case (m_ph[k])
            P_HOLD: begin
              m_v[k]   = 1;
              m_out[k] = din[m_own[k]];
              if (k == 0) qs0.push_back(m_out[k]); else qs1.push_back(m_out[k]);
              m_left[k]--;
              if (!en || m_left[k] == 0 || !req[m_own[k]]) begin
                m_g[k]    = 0;
                m_last[k] = m_own[k];
                m_ph[k]   = (en && req != 0) ? P_ARB : P_IDLE;
              end
            end
            P_ARB: begin
              m_ph[k] = P_IDLE;
              if (en) begin
                for (int i = 1; i <= 4; i++) begin
                  c = (m_last[k] + i) % 4;
                  if (req[c] && m_ph[k] != P_HOLD) begin
                    m_own[k] = c; m_left[k] = dw[k]; m_g[k] = 1; m_ph[k] = P_HOLD;
                  end
                end
              end
            end
            default: m_ph[k] = (en && req != 0) ? P_ARB : P_IDLE;
          endcase
        end
        e[k].sel   = 2'(m_own[k]);
        e[k].grant = m_g[k] ? (4'b0001 << m_own[k]) : 4'b0000;
        e[k].out   = m_out[k];
        e[k].ov    = m_v[k];
      end
      qc.push_back(e);
    end
  end

  // Monitor: per-cycle outputs, plus a sample pop whenever out_valid is seen.
  initial begin
    exp2_t e;
    bit    s;
    forever begin
      @(posedge clk);
      #1;
      if (qc.size() == 0) fail("cycle_queue_empty");
      else begin
        e = qc.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("d%0d_sel", dw[k]), 32'(sel[k]), 32'(e[k].sel));
          chk($sformatf("d%0d_grant", dw[k]), 32'(grant[k]), 32'(e[k].grant));
          chk($sformatf("d%0d_out_valid", dw[k]), 32'(ov[k]), 32'(e[k].ov));
          chk($sformatf("d%0d_out", dw[k]), 32'(out[k]), 32'(e[k].out));
          if (ov[k] === 1'b1) begin
            if ((k == 0 && qs0.size() == 0) || (k == 1 && qs1.size() == 0))
              fail($sformatf("d%0d_unexpected_sample", dw[k]));
            else begin
              s = (k == 0) ? qs0.pop_front() : qs1.pop_front();
              chk($sformatf("d%0d_sample", dw[k]), 32'(out[k]), 32'(s));
            end
          end
        end
      end
    end
  end

  task automatic cyc(input bit e, input logic [3:0] r);
    @(negedge clk);
    en  = e;
    req = r;
    din = 4'($urandom);
  endtask

  // Drive full contention until DWELL=4 instance holds channel 1 (bounded).
  task automatic wait_ch1(output bit ok);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      cyc(1, 4'b1111);
      if (m_g[0] && m_own[0] == 1) ok = 1;
    end
    if (!ok) fail("wait_grant_ch1_timeout");
  endtask

  initial begin
    bit         ok;
    logic [3:0] r;
    rst = 1'b0; en = 1'b0; req = 4'b0; din = 4'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single requester, then full contention.
    repeat (14) cyc(1, 4'b0100);
    repeat (3)  cyc(1, 4'b0000);
    repeat (45) cyc(1, 4'b1111);

    // Abort: en falls mid-grant, then contention with en low.
    repeat (4) cyc(1, 4'b1111);
    repeat (8) cyc(0, 4'b1111);

    // Early drop of channel 1 with channels 0 and 3 still requesting.
    wait_ch1(ok);
    repeat (12) cyc(1, 4'b1001);

    // Asynchronous reset while channel 1 is granted.
    wait_ch1(ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_rst_sel", dw[k]), 32'(sel[k]), 32'd0);
      chk($sformatf("d%0d_rst_grant", dw[k]), 32'(grant[k]), 32'd0);
      chk($sformatf("d%0d_rst_out", dw[k]), 32'(out[k]), 32'd0);
      chk($sformatf("d%0d_rst_out_valid", dw[k]), 32'(ov[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) cyc(1, 4'b1111);

    // Wrap after channel 3 and sole requester on channel 3.
    repeat (12) cyc(1, 4'b1000);
    repeat (12) cyc(1, 4'b1001);

    // Randomized requests with persistence and occasional en drops.
    r = 4'($urandom);
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) r = r ^ 4'(1 << $urandom_range(0, 3));
      cyc($urandom_range(0, 9) != 0, r);
    end

    repeat (10) cyc(0, 4'b0000);
    chk("samples_left_d4", 32'(qs0.size()), 32'd0);
    chk("samples_left_d1", 32'(qs1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
